// File: rtl/vmem_local_dma.sv
// Block-transfer sequencer for port B of the per-lane vector local memory (load: stream->mem, store: mem->stream).
// Latency: load writes in the cycle of each input handshake; store gives first rden at T+1, first out_valid at T+3 after command accept at T.
// Backpressure: load stalls on in_valid; store holds at most 2 rows (FIFO + in-flight read) and stops issuing reads while that credit is used up.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_dir/cmd_addr/cmd_len/cmd_mask describe the transfer
//   in_valid/in_ready/in_data   load row stream
//   out_valid/out_ready/out_data store row stream
//   mem_*_b, mem_en, mem_out_b  memory port B (read data returns the cycle after mem_rden_b)
//   busy, done                  transfer in progress / one-cycle completion pulse
module vmem_local_dma #(
    parameter int NUMLANES     = 8,
    parameter int DATAWORDSIZE = 32,
    parameter int MEMDEPTH     = 2048,
    parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH),
    parameter int LENWIDTH     = LOGMEMDEPTH + 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_dir,
    input  logic [LOGMEMDEPTH-1:0]           cmd_addr,
    input  logic [LENWIDTH-1:0]              cmd_len,
    input  logic [NUMLANES-1:0]              cmd_mask,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUMLANES*DATAWORDSIZE-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUMLANES*DATAWORDSIZE-1:0] out_data,
    output logic [LOGMEMDEPTH-1:0]           mem_address_b,
    output logic                             mem_rden_b,
    output logic                             mem_wren_b,
    output logic [NUMLANES-1:0]              mem_en,
    output logic [NUMLANES*DATAWORDSIZE-1:0] mem_data_b,
    input  logic [NUMLANES*DATAWORDSIZE-1:0] mem_out_b,
    output logic                             busy,
    output logic                             done
);
    localparam int RW = NUMLANES * DATAWORDSIZE;

    typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

    state_t                 state;
    logic [LOGMEMDEPTH-1:0] addr;
    logic [LENWIDTH-1:0]    len;
    logic [LENWIDTH-1:0]    remaining;
    logic [LENWIDTH-1:0]    issued;
    logic [LENWIDTH-1:0]    delivered;
    logic [NUMLANES-1:0]    mask;
    logic [RW-1:0]          fifo_q0;     // head
    logic [RW-1:0]          fifo_q1;
    logic [1:0]             fifo_count;
    logic                   inflight;    // read issued last cycle, data on mem_out_b now
    logic                   done_q;

    logic                   cmd_fire;
    logic                   load_hs;
    logic                   pop;
    logic                   issue;
    logic [2:0]             occupancy;
    logic [LOGMEMDEPTH-1:0] addr_next;

    // Explicit wrap keeps the address modulo MEMDEPTH even when it is not a power of two.
    assign addr_next = (addr == LOGMEMDEPTH'(MEMDEPTH - 1)) ? '0 : addr + LOGMEMDEPTH'(1);

    assign cmd_ready = (state == IDLE) && !reset;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign in_ready  = (state == LOAD) && !reset;
    assign load_hs   = in_valid && in_ready;

    assign out_valid = (fifo_count != 2'd0) && !reset;
    assign out_data  = fifo_q0;
    assign pop       = out_valid && out_ready;

    // Rows that will be held after this cycle if no new read is issued: a slot freed
    // by a pop this cycle can be reused immediately, which sustains 1 row/cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == STORE) && !reset && (issued < len) && (occupancy < 3'd2);

    assign mem_wren_b    = load_hs;
    assign mem_rden_b    = issue;
    assign mem_en        = load_hs ? mask : '0;
    assign mem_data_b    = in_data;
    assign mem_address_b = (load_hs || issue) ? addr : '0;

    assign busy = (state != IDLE);
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            len        <= '0;
            remaining  <= '0;
            issued     <= '0;
            delivered  <= '0;
            mask       <= '0;
            fifo_q0    <= '0;
            fifo_q1    <= '0;
            fifo_count <= '0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue;

            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        addr      <= cmd_addr;
                        len       <= cmd_len;
                        remaining <= cmd_len;
                        mask      <= cmd_mask;
                        issued    <= '0;
                        delivered <= '0;
                        if (cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= cmd_dir ? STORE : LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (load_hs) begin
                        addr      <= addr_next;
                        remaining <= remaining - LENWIDTH'(1);
                        if (remaining == LENWIDTH'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                STORE: begin
                    if (issue) begin
                        addr   <= addr_next;
                        issued <= issued + LENWIDTH'(1);
                    end
                    // Every issued row is delivered before this fires, so the FIFO
                    // and in-flight slot are already empty when returning to IDLE.
                    if (pop) begin
                        delivered <= delivered + LENWIDTH'(1);
                        if (delivered + LENWIDTH'(1) == len) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Output FIFO: push is the read data returning for last cycle's issue.
            case ({inflight, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) fifo_q0 <= mem_out_b;
                    else                    fifo_q1 <= mem_out_b;
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_q0    <= fifo_q1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_q0 <= mem_out_b;
                    end else begin
                        fifo_q0 <= fifo_q1;
                        fifo_q1 <= mem_out_b;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vmem_local_dma.sv
module tb_vmem_local_dma;
    localparam int NL = 8, DWS = 32, DEPTH = 2048, AW = 11, LW = 12, RW = NL * DWS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [NL-1:0] cmd_mask = '0;
    logic          in_valid, in_ready;
    logic [RW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [RW-1:0] out_data;
    logic [AW-1:0] mem_address_b;
    logic          mem_rden_b, mem_wren_b;
    logic [NL-1:0] mem_en;
    logic [RW-1:0] mem_data_b;
    logic [RW-1:0] mem_out_b = '0;
    logic          busy, done;

    vmem_local_dma #(.NUMLANES(NL), .DATAWORDSIZE(DWS), .MEMDEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_mask(cmd_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_address_b(mem_address_b), .mem_rden_b(mem_rden_b), .mem_wren_b(mem_wren_b),
        .mem_en(mem_en), .mem_data_b(mem_data_b), .mem_out_b(mem_out_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [RW-1:0] d;
        logic [NL-1:0] m;
    } wr_t;

    // Port B memory seen by the DUT, and the reference contents the model predicts.
    logic [RW-1:0] mem    [DEPTH];
    logic [RW-1:0] shadow [DEPTH];

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [RW-1:0] exp_out[$];
    logic [RW-1:0] in_q[$];
    logic [RW-1:0] last_rows[$];

    int            wr_log_addr[$], wr_log_cyc[$], out_cyc[$];
    logic [RW-1:0] out_log[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, acc_cyc = 0, done_cyc = 0, done_cnt = 0, exp_done = 0;
    int first_ov_cyc = -1, first_rd_cyc = -1, n_rd = 0, n_wr = 0, outstanding = 0, mon_o = 0;
    int in_pct = 100, cons_mode = 0, cons_k = 0;
    bit mon_on = 1'b0, feed_hs = 1'b0;
    wr_t mon_e;

    function automatic logic [RW-1:0] merge(input logic [RW-1:0] old, input logic [RW-1:0] nw,
                                            input logic [NL-1:0] m);
        logic [RW-1:0] r;
        r = old;
        for (int l = 0; l < NL; l++)
            if (m[l]) r[l*DWS +: DWS] = nw[l*DWS +: DWS];
        return r;
    endfunction

    function automatic logic [RW-1:0] make_row(input int pat, input int i);
        logic [RW-1:0] r;
        for (int l = 0; l < NL; l++)
            r[l*DWS +: DWS] = (pat == 0) ? $urandom : {pat[15:0], i[7:0], l[7:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wren_b) mem[mem_address_b] <= merge(mem[mem_address_b], mem_data_b, mem_en);
        if (mem_rden_b) mem_out_b <= mem[mem_address_b];
    end

    // Load source: offers queued rows, sometimes idling.
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            feed_hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (feed_hs) in_q.delete(0);
            if (in_q.size() > 0 && $urandom_range(99) < in_pct) begin
                in_valid = 1'b1;
                in_data  = in_q[0];
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
    end

    // Store sink: 0 always ready, 1 pattern 1,0,0,..., 2 random, 3 driven by the main sequence.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (cons_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (cons_k % 3 == 0); cons_k++; end
                2: out_ready = 1'($urandom_range(1));
                default: ;
            endcase
        end
    end

    // Compare process: every port-B access and every delivered row against the model.
    always @(negedge clk) begin
        if (!reset && mon_on) begin
            chk("rd_wr_exclusive", {255'd0, mem_rden_b & mem_wren_b}, '0);
            if (mem_wren_b) begin
                n_wr++;
                wr_log_addr.push_back(int'(mem_address_b));
                wr_log_cyc.push_back(cyc);
                chk("wren_expected", {255'd0, exp_wr.size() != 0}, 1);
                if (exp_wr.size() != 0) begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", mem_address_b, mon_e.a);
                    chk("wr_data", mem_data_b, mon_e.d);
                    chk("wr_en", mem_en, mon_e.m);
                end
            end else begin
                chk("en_without_write", mem_en, '0);
            end
            if (mem_rden_b) begin
                n_rd++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                chk("rden_expected", {255'd0, exp_rd.size() != 0}, 1);
                if (exp_rd.size() != 0) chk("rd_addr", mem_address_b, exp_rd.pop_front());
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
                out_log.push_back(out_data);
                out_cyc.push_back(cyc);
                chk("out_expected", {255'd0, exp_out.size() != 0}, 1);
                if (exp_out.size() != 0) chk("out_data", out_data, exp_out.pop_front());
            end
            mon_o = outstanding + (mem_rden_b ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            chk("buffered_le_2", {255'd0, mon_o <= 2}, 1);
            outstanding = mon_o;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, '0);
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic send_cmd(input bit dir, input int a, input int len, input logic [NL-1:0] m);
        int t = 0;
        cmd_dir   = dir;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(len);
        cmd_mask  = m;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 100);
        chk("cmd_accepted", cmd_ready, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        int t = 0;
        while (done_cnt == start && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk("done_seen", {255'd0, done_cnt > start}, 1);
        #1;
    endtask

    task automatic do_load(input int a, input int len, input logic [NL-1:0] m, input int pat);
        int start = done_cnt;
        logic [RW-1:0] row;
        last_rows.delete();
        for (int i = 0; i < len; i++) begin
            int ad = (a + i) % DEPTH;
            row = make_row(pat, i);
            exp_wr.push_back('{AW'(ad), row, m});
            in_q.push_back(row);
            last_rows.push_back(row);
            shadow[ad] = merge(shadow[ad], row, m);
        end
        wr_log_addr.delete();
        wr_log_cyc.delete();
        send_cmd(1'b0, a, len, m);
        exp_done++;
        wait_done(start, 40 * len + 20);
        chk("load_all_written", exp_wr.size(), 0);
    endtask

    task automatic do_store(input int a, input int len);
        int start = done_cnt;
        for (int i = 0; i < len; i++) begin
            int ad = (a + i) % DEPTH;
            exp_rd.push_back(AW'(ad));
            exp_out.push_back(shadow[ad]);
        end
        out_log.delete();
        out_cyc.delete();
        first_ov_cyc = -1;
        first_rd_cyc = -1;
        send_cmd(1'b1, a, len, '0);
        exp_done++;
        wait_done(start, 40 * len + 20);
        chk("store_all_read", exp_rd.size(), 0);
        chk("store_all_out", exp_out.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] t1_rows[$];
        logic [RW-1:0] exp_row;
        int wrap_exp[4];
        int start, rd0, wr0, t;
        wrap_exp = '{2046, 2047, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rden", mem_rden_b, 0);
        chk("rst_wren", mem_wren_b, 0);
        chk("rst_en", mem_en, 0);
        chk("rst_addr", mem_address_b, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Load 4 rows at 10, source always valid
        in_pct = 100;
        do_load(10, 4, 8'hFF, 0);
        t1_rows = last_rows;
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_addr", wr_log_addr[i], 10 + i);
            chk("t1_wr_cycle", wr_log_cyc[i], acc_cyc + 1 + i);
        end
        chk("t1_done_cycle", done_cyc, wr_log_cyc[3] + 1);

        // Store them back, sink always ready
        cons_mode = 0;
        do_store(10, 4);
        chk("t2_first_rden", first_rd_cyc, acc_cyc + 1);
        chk("t2_first_out_valid", first_ov_cyc, acc_cyc + 3);
        for (int i = 0; i < 4; i++) begin
            chk("t2_out_cycle", out_cyc[i], acc_cyc + 3 + i);
            chk("t2_row_matches_load", out_log[i], t1_rows[i]);
        end

        // Store 6 rows with a stalling sink
        cons_k = 0;
        cons_mode = 1;
        do_store(10, 6);
        chk("t3_rows", out_log.size(), 6);

        // Address wrap
        cons_mode = 0;
        do_load(2046, 4, 8'hFF, 0);
        for (int i = 0; i < 4; i++) chk("wrap_addr", wr_log_addr[i], wrap_exp[i]);

        // Lane mask over pre-filled rows
        do_load(20, 2, 8'hFF, 16'h1111);
        do_load(20, 2, 8'h0F, 16'h2222);
        do_store(20, 2);
        for (int i = 0; i < 2; i++) begin
            for (int l = 0; l < NL; l++)
                exp_row[l*DWS +: DWS] = (l < 4) ? (32'h2222_0000 + i * 256 + l) : (32'h1111_0000 + i * 256 + l);
            chk("mask_lanes", out_log[i], exp_row);
        end

        // Zero-length commands
        rd0 = n_rd;
        wr0 = n_wr;
        do_load(50, 0, 8'hFF, 0);
        chk("len0_load_done_cycle", done_cyc, acc_cyc + 1);
        do_store(50, 0);
        chk("len0_store_done_cycle", done_cyc, acc_cyc + 1);
        chk("len0_no_rden", n_rd, rd0);
        chk("len0_no_wren", n_wr, wr0);

        // Reset after 2 of 5 store rows delivered
        cons_mode = 3;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_rd.push_back(AW'(10 + i));
            exp_out.push_back(shadow[10 + i]);
        end
        out_log.delete();
        send_cmd(1'b1, 10, 5, '0);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_test_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_test_two_rows", out_log.size(), 2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_rd.delete();
        exp_out.delete();
        outstanding = 0;
        start = done_cnt;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_rden", mem_rden_b, 0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, start);
        @(posedge clk);
        #1;
        cons_mode = 0;
        do_load(100, 3, 8'hFF, 0);
        do_store(100, 3);

        // Randomized commands
        for (int k = 0; k < 25; k++) begin
            int a, len;
            a = $urandom_range(DEPTH - 1);
            len = $urandom_range(12);
            in_pct = $urandom_range(100, 30);
            cons_mode = $urandom_range(2);
            if ($urandom_range(1) == 0) do_load(a, len, NL'($urandom), 0);
            else                        do_store(a, len);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("done_total", done_cnt, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vmem_local_dma.md
Name: vmem_local_dma

Overview:
- Block-transfer sequencer for port B of the per-lane vector local memory.
- Accepts one command at a time: base row address, row count, lane mask and direction.
- Load (dir=0): streams rows in from a valid/ready source and writes them through port B.
- Store (dir=1): reads rows through port B and streams them out. Handles the memory's 1-cycle read latency and downstream backpressure without losing data.

Parameters:
- NUMLANES, 8, lanes per row (one DATAWORDSIZE word per lane).
- DATAWORDSIZE, 32, bits per lane word.
- MEMDEPTH, 2048, rows per lane memory.
- LOGMEMDEPTH, $clog2(MEMDEPTH), row address width.
- LENWIDTH, LOGMEMDEPTH+1, row-count width (allows a full-memory transfer).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_dir  in  1  0=load (stream->memory write), 1=store (memory read->stream).
- cmd_addr  in  LOGMEMDEPTH  first row address.
- cmd_len  in  LENWIDTH  number of rows.
- cmd_mask  in  NUMLANES  per-lane write enable for loads.
- in_valid  in  1  load data present.
- in_ready  out  1  load data accepted.
- in_data  in  NUMLANES*DATAWORDSIZE  load row.
- out_valid  out  1  store data present.
- out_ready  in  1  consumer accepts store data.
- out_data  out  NUMLANES*DATAWORDSIZE  store row.
- mem_address_b  out  LOGMEMDEPTH  port B row address.
- mem_rden_b  out  1  port B read strobe.
- mem_wren_b  out  1  port B write strobe.
- mem_en  out  NUMLANES  lane enables (gate writes only).
- mem_data_b  out  NUMLANES*DATAWORDSIZE  port B write data.
- mem_out_b  in  NUMLANES*DATAWORDSIZE  port B read data, valid the cycle after mem_rden_b.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, LOAD, STORE.
- Reset values: state=IDLE, FIFO empty, in-flight flag=0, counters=0. Outputs: cmd_ready=0 during the reset cycle, then 1; in_ready=0, out_valid=0, mem_rden_b=0, mem_wren_b=0, mem_en=0, mem_address_b=0, busy=0, done=0.
- Reset mid-transfer: return to IDLE, drop FIFO contents, discard in-flight read data. No done pulse.
- cmd_ready=1 only in IDLE.
- On acceptance, latch addr, len and mask, and clear issued/delivered counters.
  - cmd_len=0: stay IDLE; done=1 the next cycle; no memory access.
  - Otherwise go to LOAD or STORE; busy=1 from the next cycle.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready cycle drives, combinationally in that same cycle: mem_wren_b=1, mem_address_b=current addr, mem_data_b=in_data, mem_en=mask.
  - Then addr<=addr+1, remaining<=remaining-1.
  - The handshake for the final row moves the block to IDLE and pulses done the next cycle.
  - mem_wren_b=0 whenever there is no handshake.
- STORE:
  - 2-entry output FIFO plus an in-flight flag (a read issued last cycle).
  - Read issue condition: issued<len and (fifo_count - pop + inflight) < 2, where pop = out_valid&out_ready in the same cycle.
  - On issue: mem_rden_b=1, mem_address_b=addr, addr<=addr+1.
  - mem_out_b is pushed into the FIFO in the cycle after issue.
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - mem_wren_b=0 and mem_en=0 throughout STORE.
  - Latency: command accepted in cycle T, first rden in T+1, first out_valid in T+3.
  - With out_ready held high, throughput is 1 row/cycle.
  - When the delivered count reaches len on a handshake: go to IDLE, done pulse the next cycle.
- Address arithmetic is modulo MEMDEPTH: MEMDEPTH-1 wraps to 0.
- Transfers longer than MEMDEPTH rows are not checked; the address keeps wrapping.
- A new command can be accepted in the cycle done is high, since state is IDLE by then.
- Port A is not touched; arbitration against port A is outside this block.

Test Plan:
- Load addr=10, len=4, mask=0xFF, in_valid always 1 -> wren at addrs 10..13 on 4 consecutive cycles, done 1 cycle after the last write, busy low after.
- Store addr=10, len=4, out_ready=1 -> first out_valid at T+3, 4 rows on consecutive cycles, data equal to the rows loaded above, one done pulse.
- Store len=6 with out_ready toggling 1,0,0,1,... -> no row lost or duplicated, order preserved, at most 2 buffered rows, rden stalls while credit=0.
- Load addr=2046, len=4 -> write addresses 2046, 2047, 0, 1.
- Load with mask=0x0F over pre-filled memory, then store the same rows -> lanes 4-7 unchanged, lanes 0-3 updated.
- cmd_len=0 -> no rden/wren, done one cycle after acceptance.
- Reset asserted mid-store after 2 of 5 rows -> out_valid=0 and state IDLE next cycle, no done. A following load is accepted normally.
